// File: rtl/mul3_seq.sv
// mul3_seq: 4x4 Q13 matrix product C = A x B using one time-multiplexed MAC, streamed in and out row-major.
module mul3_seq #(
    parameter int DW   = 26,
    parameter int FRAC = 13
) (
    input  logic                 clk_mul,
    input  logic                 rstn_mul,
    input  logic                 en_mul,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_a,
    input  logic signed [DW-1:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 busy
);
    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_COMP = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;
    logic [1:0]               r_state;
    logic [3:0]               r_idx;
    logic [3:0]               r_oidx;
    logic [5:0]               r_cnt;
    logic                     r_byp;
    logic signed [2*DW+1:0]   r_acc;
    logic signed [DW-1:0]     r_dout;
    logic signed [DW-1:0]     r_a [16];
    logic signed [DW-1:0]     r_b [16];
    logic signed [DW-1:0]     r_c [16];
    logic signed [2*DW-1:0]   w_prod;
    logic signed [2*DW+1:0]   w_base;
    logic signed [2*DW+1:0]   w_acc_next;
    logic signed [DW-1:0]     w_res;
    logic [3:0]               w_onext;
    // r_cnt packs {i, j, k}: k is fastest, so (i, j) advance row-major every 4 MACs
    assign w_prod     = r_a[{r_cnt[5:4], r_cnt[1:0]}] * r_b[{r_cnt[1:0], r_cnt[3:2]}];
    assign w_base     = (r_cnt[1:0] == 2'd0) ? '0 : r_acc;
    assign w_acc_next = w_base + w_prod;
    assign w_res      = w_acc_next[FRAC+DW-1:FRAC];
    assign w_onext    = r_oidx + 4'd1;
    assign in_ready   = (r_state == S_LOAD);
    assign out_valid  = (r_state == S_OUT);
    assign busy       = (r_state != S_LOAD);
    assign out_data   = r_dout;
    always_ff @(posedge clk_mul) begin
        if (!rstn_mul) begin
            r_state <= S_LOAD;
            r_idx   <= '0;
            r_oidx  <= '0;
            r_cnt   <= '0;
            r_byp   <= 1'b0;
            r_acc   <= '0;
            r_dout  <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (in_valid) begin
                        r_a[r_idx] <= in_a;
                        r_b[r_idx] <= in_b;
                        r_idx      <= r_idx + 4'd1;
                        if (r_idx == 4'd0)
                            r_byp <= !en_mul;
                        if (r_idx == 4'd15) begin
                            if (r_byp) begin
                                r_state   <= S_OUT;
                                r_c       <= r_a;
                                r_c[15]   <= in_a;
                                r_dout    <= r_a[0];
                            end else begin
                                r_state <= S_COMP;
                                r_cnt   <= '0;
                                r_acc   <= '0;
                            end
                        end
                    end
                end
                S_COMP: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt[1:0] == 2'd3)
                        r_c[r_cnt[5:2]] <= w_res;
                    if (r_cnt == 6'd63) begin
                        r_state <= S_OUT;
                        r_dout  <= r_c[0];
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_oidx <= w_onext;
                        r_dout <= (r_oidx == 4'd15) ? '0 : r_c[w_onext];
                        if (r_oidx == 4'd15)
                            r_state <= S_LOAD;
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_mul3_seq.sv
// tb_mul3_seq: directed vectors with hand-computed results for the streamed 4x4 matrix multiplier.
module tb_mul3_seq;
    localparam int DW = 26;
    typedef logic signed [DW-1:0] mat_t [16];
    logic clk_mul = 1'b0;
    logic rstn_mul = 1'b0;
    logic en_mul = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic signed [DW-1:0] in_a = '0;
    logic signed [DW-1:0] in_b = '0;
    logic in_ready, out_valid, busy;
    logic signed [DW-1:0] out_data;
    mat_t ma, mb, me;
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk_mul = ~clk_mul;
    mul3_seq #(.DW(DW), .FRAC(13)) dut (
        .clk_mul(clk_mul), .rstn_mul(rstn_mul), .en_mul(en_mul),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );
    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic load(input logic en, input bit tog, input int maxgap);
        for (int n = 0; n < 16; n++) begin
            repeat ($urandom_range(0, maxgap)) begin
                in_valid = 1'b0;
                @(negedge clk_mul);
            end
            chk("load_in_ready", in_ready, 1);
            chk("load_no_out", out_valid, 0);
            in_valid = 1'b1;
            in_a = ma[n];
            in_b = mb[n];
            en_mul = (n == 0) ? en : (tog ? ~en_mul : en);
            @(negedge clk_mul);
        end
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
    endtask
    task automatic drain(input string tag, input int lat, input bit stall);
        int c, k, st;
        c = 1;
        while (!out_valid && c < 200) begin
            chk({tag, "_busy_compute"}, busy, 1);
            chk({tag, "_in_ready_compute"}, in_ready, 0);
            @(negedge clk_mul);
            c++;
        end
        chk({tag, "_latency"}, c, lat);
        k = 0;
        st = 0;
        for (int g = 0; g < 40 && k < 16; g++) begin
            chk({tag, "_valid"}, out_valid, 1);
            chk({tag, "_data"}, out_data, me[k]);
            chk({tag, "_in_ready_out"}, in_ready, 0);
            chk({tag, "_busy_out"}, busy, 1);
            if (stall && k == 7 && st < 5) begin
                out_ready = 1'b0;
                st++;
            end else begin
                out_ready = 1'b1;
                k++;
            end
            @(negedge clk_mul);
        end
        out_ready = 1'b1;
        chk({tag, "_beats"}, k, 16);
        chk({tag, "_done_valid"}, out_valid, 0);
        chk({tag, "_done_in_ready"}, in_ready, 1);
        chk({tag, "_done_busy"}, busy, 0);
    endtask
    initial begin
        repeat (2) @(negedge clk_mul);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        rstn_mul = 1'b1;
        @(negedge clk_mul);
        for (int n = 0; n < 16; n++) begin
            ma[n] = DW'((n % 5 == 0) ? 8192 : 0);
            mb[n] = DW'((n - 8) * 4096);
            me[n] = mb[n];
        end
        load(1'b1, 1'b0, 0);
        drain("ident", 65, 1'b0);
        for (int n = 0; n < 16; n++) begin
            ma[n] = DW'((n % 5 == 0) ? 2048 : 0);
            mb[n] = DW'((n % 5 == 0) ? 4096 : 0);
            me[n] = DW'((n % 5 == 0) ? 1024 : 0);
        end
        load(1'b1, 1'b0, 0);
        drain("scalar_pos", 65, 1'b0);
        for (int n = 0; n < 16; n++) begin
            ma[n] = DW'((n % 5 == 0) ? -8192 : 0);
            mb[n] = DW'((n % 5 == 0) ? 12288 : 0);
            me[n] = DW'((n % 5 == 0) ? -12288 : 0);
        end
        load(1'b1, 1'b0, 0);
        drain("scalar_neg", 65, 1'b0);
        for (int n = 0; n < 16; n++) begin
            ma[n] = DW'(n);
            mb[n] = DW'(-3 * n - 1);
            me[n] = DW'(n);
        end
        load(1'b0, 1'b1, 0);
        drain("bypass", 1, 1'b0);
        for (int n = 0; n < 16; n++) begin
            ma[n] = DW'((n % 5 == 0) ? 8192 : 0);
            mb[n] = DW'(n * 1000 - 7000);
            me[n] = mb[n];
        end
        load(1'b1, 1'b1, 3);
        drain("backpressure", 65, 1'b1);
        // 4*(2^25-1)^2 = 2^52 - 2^28 + 4; bits [38:13] = 2^26 - 2^15, i.e. -32768 as 26-bit signed
        for (int n = 0; n < 16; n++) begin
            ma[n] = DW'(33554431);
            mb[n] = DW'(33554431);
            me[n] = DW'(-32768);
        end
        load(1'b1, 1'b0, 0);
        drain("overflow", 65, 1'b0);
        for (int n = 0; n < 16; n++) begin
            ma[n] = DW'((n % 5 == 0) ? 8192 : 0);
            mb[n] = DW'(5 * n + 3);
        end
        load(1'b1, 1'b0, 0);
        repeat (30) @(negedge clk_mul);
        rstn_mul = 1'b0;
        @(negedge clk_mul);
        rstn_mul = 1'b1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_data", out_data, 0);
        for (int g = 0; g < 70; g++) begin
            chk("midrst_quiet", out_valid, 0);
            @(negedge clk_mul);
        end
        for (int n = 0; n < 16; n++) begin
            mb[n] = DW'(-2048 * n + 777);
            me[n] = mb[n];
        end
        load(1'b1, 1'b0, 0);
        drain("after_rst", 65, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
